// File: rtl/semaforo.sv
// rtl/semaforo.sv - two-way traffic-light Moore FSM with button request
module semaforo #(
    parameter logic [7:0] VERDE    = 8'd1,
    parameter logic [7:0] AMARELO  = 8'd15,
    parameter logic [7:0] VERMELHO = 8'd10
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bt,
    output logic [2:0] A,
    output logic [2:0] B
);

    localparam logic [1:0] S_AG = 2'd0;
    localparam logic [1:0] S_AY = 2'd1;
    localparam logic [1:0] S_BG = 2'd2;
    localparam logic [1:0] S_BY = 2'd3;

    // Zero-length phases are treated as one cycle long.
    localparam logic [7:0] V_EFF = (VERDE    == 8'd0) ? 8'd1 : VERDE;
    localparam logic [7:0] Y_EFF = (AMARELO  == 8'd0) ? 8'd1 : AMARELO;
    localparam logic [7:0] R_EFF = (VERMELHO == 8'd0) ? 8'd1 : VERMELHO;

    localparam logic [7:0] V_END = V_EFF - 8'd1;
    localparam logic [7:0] Y_END = Y_EFF - 8'd1;
    // B yellow takes the last red cycle, so B green ends one cycle earlier.
    localparam logic [7:0] R_END = (R_EFF < 8'd2) ? 8'd0 : (R_EFF - 8'd2);
    localparam logic       SKIP_BG = (R_EFF == 8'd1);

    logic [1:0] state;
    logic [1:0] state_nxt;
    logic [7:0] cnt;
    logic       req;
    logic       req_nxt;

    always_comb begin
        state_nxt = state;
        case (state)
            S_AG: if (cnt == V_END || req || bt) state_nxt = S_AY;
            S_AY: if (cnt == Y_END) state_nxt = SKIP_BG ? S_BY : S_BG;
            S_BG: if (cnt == R_END) state_nxt = S_BY;
            default: state_nxt = S_AG;
        endcase
    end

    always_comb begin
        req_nxt = req;
        if (state == S_AG && state_nxt == S_AY)
            req_nxt = 1'b0;
        else if (bt && state != S_AG)
            req_nxt = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_AG;
            cnt   <= 8'd0;
            req   <= 1'b0;
        end else begin
            state <= state_nxt;
            cnt   <= (state_nxt != state) ? 8'd0 : cnt + 8'd1;
            req   <= req_nxt;
        end
    end

    always_comb begin
        A = 3'b001;
        B = 3'b100;
        case (state)
            S_AG: begin A = 3'b001; B = 3'b100; end
            S_AY: begin A = 3'b010; B = 3'b100; end
            S_BG: begin A = 3'b100; B = 3'b001; end
            default: begin A = 3'b100; B = 3'b010; end
        endcase
    end

endmodule

// File: tb/tb_semaforo.sv
// tb/tb_semaforo.sv - directed self-checking bench for semaforo
module tb_semaforo;

    logic       clk;
    logic       rst;
    logic [3:0] bt;
    logic [2:0] a [4];
    logic [2:0] b [4];

    int checks = 0;
    int errors = 0;

    semaforo u0 (.clk(clk), .rst(rst), .bt(bt[0]), .A(a[0]), .B(b[0]));
    semaforo #(.VERDE(8'd20)) u1 (.clk(clk), .rst(rst), .bt(bt[1]), .A(a[1]), .B(b[1]));
    semaforo #(.VERMELHO(8'd1)) u2 (.clk(clk), .rst(rst), .bt(bt[2]), .A(a[2]), .B(b[2]));
    semaforo #(.VERDE(8'd255), .AMARELO(8'd255)) u3 (.clk(clk), .rst(rst), .bt(bt[3]), .A(a[3]), .B(b[3]));

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic tickn(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    // Expected lamps for a free-running cycle with the given phase lengths.
    task automatic run_expect(input int sel, input int ng, input int ny, input int nbg,
                              input int nby, input int ncyc);
        int per;
        int p;
        logic [2:0] ea;
        logic [2:0] eb;
        per = ng + ny + nbg + nby;
        for (int k = 0; k < ncyc; k++) begin
            p = k % per;
            if (p < ng) begin ea = 3'b001; eb = 3'b100; end
            else if (p < ng + ny) begin ea = 3'b010; eb = 3'b100; end
            else if (p < ng + ny + nbg) begin ea = 3'b100; eb = 3'b001; end
            else begin ea = 3'b100; eb = 3'b010; end
            check($sformatf("run%0d_A_c%0d", sel, k), {29'd0, a[sel]}, {29'd0, ea});
            check($sformatf("run%0d_B_c%0d", sel, k), {29'd0, b[sel]}, {29'd0, eb});
            tick();
        end
    endtask

    initial begin
        logic ok;
        rst = 1'b0;
        bt  = 4'b0000;
        #2;

        // Reset with a pending press: the press must be ignored.
        rst = 1'b1;
        bt[0] = 1'b1;
        tick();
        check("rst_A", {29'd0, a[0]}, 32'h1);
        check("rst_B", {29'd0, b[0]}, 32'h4);
        check("rst_cnt", {24'd0, u0.cnt}, 32'd0);
        check("rst_req", {31'd0, u0.req}, 32'd0);
        rst = 1'b0;
        bt[0] = 1'b0;

        // Two default periods: 1 green, 15 yellow, 9 B green, 1 B yellow.
        run_expect(0, 1, 15, 9, 1, 52);

        // Early termination with VERDE=20.
        do_reset();
        check("et_c0", {29'd0, a[1]}, 32'h1);
        for (int i = 1; i <= 4; i++) begin
            tick();
            check($sformatf("et_green_%0d", i), {29'd0, a[1]}, 32'h1);
        end
        bt[1] = 1'b1;
        tick();
        bt[1] = 1'b0;
        check("et_yellow", {29'd0, a[1]}, 32'h2);
        check("et_cnt0", {24'd0, u1.cnt}, 32'd0);
        tickn(14);
        check("et_yellow_last", {29'd0, a[1]}, 32'h2);
        tick();
        check("et_red_A", {29'd0, a[1]}, 32'h4);
        check("et_red_B", {29'd0, b[1]}, 32'h1);

        // Latched request with VERDE=20: two presses during A yellow.
        do_reset();
        tickn(20);
        check("lr_yellow", {29'd0, a[1]}, 32'h2);
        bt[1] = 1'b1; tick();
        bt[1] = 1'b0; tick();
        bt[1] = 1'b1; tick();
        bt[1] = 1'b0;
        check("lr_req_set", {31'd0, u1.req}, 32'd1);
        tickn(22);
        check("lr_green_short", {29'd0, a[1]}, 32'h1);
        tick();
        check("lr_yellow2", {29'd0, a[1]}, 32'h2);
        check("lr_req_clr", {31'd0, u1.req}, 32'd0);
        tickn(25);
        check("lr_green_full0", {29'd0, a[1]}, 32'h1);
        tickn(19);
        check("lr_green_full19", {29'd0, a[1]}, 32'h1);
        tick();
        check("lr_yellow3", {29'd0, a[1]}, 32'h2);

        // VERMELHO=1: no B green, one cycle of B yellow.
        do_reset();
        run_expect(2, 1, 15, 0, 1, 34);

        // VERDE=AMARELO=255: counter tops out at 254 without wrapping.
        do_reset();
        tickn(254);
        check("max_g_cnt", {24'd0, u3.cnt}, 32'd254);
        check("max_g_A", {29'd0, a[3]}, 32'h1);
        tick();
        check("max_y_A", {29'd0, a[3]}, 32'h2);
        check("max_y_cnt", {24'd0, u3.cnt}, 32'd0);
        tickn(254);
        check("max_y_end_cnt", {24'd0, u3.cnt}, 32'd254);
        check("max_y_end_A", {29'd0, a[3]}, 32'h2);
        tick();
        check("max_red_A", {29'd0, a[3]}, 32'h4);
        check("max_red_B", {29'd0, b[3]}, 32'h1);

        // Mid-phase reset during B green.
        do_reset();
        tickn(16);
        check("mr_bg_B", {29'd0, b[0]}, 32'h1);
        rst = 1'b1;
        bt[0] = 1'b1;
        tick();
        check("mr_A", {29'd0, a[0]}, 32'h1);
        check("mr_B", {29'd0, b[0]}, 32'h4);
        check("mr_cnt", {24'd0, u0.cnt}, 32'd0);
        rst = 1'b0;
        bt[0] = 1'b0;
        tick();
        check("mr_after_A", {29'd0, a[0]}, 32'h2);

        // Random button traffic: one lamp per light, never both non-red.
        for (int i = 0; i < 1000; i++) begin
            bt[0] = 1'($urandom_range(0, 1));
            tick();
            ok = $onehot(a[0]) && $onehot(b[0]) && (a[0] == 3'b100 || b[0] == 3'b100);
            check($sformatf("inv_%0d", i), {31'd0, ok}, 32'd1);
        end
        bt[0] = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
